stopwatch_ctrl: RTL and testbench
=================================

Name: stopwatch_ctrl

Overview:
- Consumes the single-cycle press pulses from the per-button debounce stages.
- Runs the stopwatch control FSM (STOP / RUN / CLEAR) and the time-of-run datapath: a 1/100 s tick divider cascading into centisecond, second, minute and hour counters.
- Outputs feed the FND display formatter downstream.

Parameters:
- CLK_FREQ_HZ, 100_000_000, system clock frequency.
- TICK_HZ, 100, count resolution. Divider modulus DIV = CLK_FREQ_HZ/TICK_HZ; must be an integer ≥ 2.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- i_btn_run_stop  input  1  debounced press pulse, 1 clk wide; toggles run/stop.
- i_btn_clear  input  1  debounced press pulse; zeroes time when stopped.
- i_btn_lap  input  1  debounced press pulse; used only with LAP_HOLD_EN.
- o_msec  output  7  centiseconds, 0..99.
- o_sec  output  6  seconds, 0..59.
- o_min  output  6  minutes, 0..59.
- o_hour  output  5  hours, 0..23.
- o_running  output  1  high while in RUN.
- o_lap_hold  output  1  display frozen (lap); constant 0 without LAP_HOLD_EN.

Interface decision: one clock, clk; reset rst is synchronous and active-high.

Behaviour:
- Reset (sampled on posedge clk while rst=1):
  - state=STOP; divider=0; all time outputs 0.
  - o_running=0, o_lap_hold=0.
  - Reset asserted mid-RUN aborts the run immediately at the next edge.
- FSM states: STOP, RUN, CLEAR.
  - STOP: i_btn_clear → CLEAR; else i_btn_run_stop → RUN. If both pulse in the same cycle, clear wins and run_stop is dropped.
  - RUN: i_btn_run_stop → STOP. i_btn_clear is ignored.
  - CLEAR: lasts exactly 1 cycle. Zeroes divider and all counters, clears lap hold, then → STOP unconditionally. Pulses arriving during CLEAR are ignored.
- o_running is registered: high the cycle after entering RUN, low the cycle after leaving it.
- Divider:
  - Increments only in RUN.
  - At DIV-1 it wraps to 0 and asserts tick for 1 cycle.
  - In STOP it holds its value, so partial-tick progress is preserved across stop/run.
- Counter cascade, evaluated on tick:
  - msec++; at 99 → 0 and carry.
  - sec++ on carry; at 59 → 0 and carry.
  - min++ on carry; at 59 → 0 and carry.
  - hour++ on carry; at 23 → 0.
  - Full wrap: 23:59:59.99 → 00:00:00.00, with no flag.
- Latency:
  - Outputs update 1 clk after the divider reaches DIV-1.
  - First increment after STOP→RUN from a zeroed divider occurs DIV cycles after o_running rises.
- Widths: exact as listed. No counter may ever exceed its limit, including after reset or clear.

Optional Feature:
- Macro: STOPWATCH_LAP_HOLD_EN.
- Defined:
  - i_btn_lap in RUN toggles o_lap_hold.
  - While hold=1, outputs show a snapshot latched at the press cycle; internal counters keep running.
  - A second lap press releases the hold; outputs show live values the next cycle.
  - Lap press in STOP is ignored.
  - RUN→STOP keeps the hold; CLEAR releases it.
- Undefined: i_btn_lap is ignored, no snapshot registers are built, o_lap_hold=0.

Decomposition:
- Package stopwatch_pkg:
  - state enum (STOP, RUN, CLEAR);
  - limit constants MSEC_MAX=99, SEC_MAX=59, MIN_MAX=59, HOUR_MAX=23;
  - output width constants.
- Sub-module stopwatch_tick_gen: parameterised divider with enable and synchronous clear inputs and a 1-cycle tick output.
- FSM and counter cascade remain in stopwatch_ctrl.

Test Plan (CLK_FREQ_HZ=1000, TICK_HZ=100, so DIV=10):
- Reset, then idle 50 clk → all outputs 0, o_running=0, no counting.
- run_stop pulse, wait 10 clk after o_running rises → o_msec=1; after 1000 clk → o_sec=1, o_msec=0.
- RUN 25 clk, run_stop (stop), wait 100 clk, run_stop (run) → count holds at 2 while stopped; next increment arrives 5 clk after resume.
- clear pulse during RUN → ignored. Then stop followed by clear → exactly 1 CLEAR cycle, all zero, state STOP. Simultaneous clear+run_stop in STOP → zeroed and remains STOP.
- Preload via a run to 23:59:59.99 (forced/backdoor), 1 more tick → 00:00:00.00; also rst asserted mid-RUN → all zero at the next edge.
- With STOPWATCH_LAP_HOLD_EN: lap press at msec=7 → outputs frozen at 7, o_lap_hold=1; after 30 clk, second lap press → outputs show live value 10.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Stopwatch shared types and limits.
// Used by stopwatch_ctrl and stopwatch_tick_gen.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    STOP  = 2'd0,
    RUN   = 2'd1,
    CLEAR = 2'd2
  } state_e;

  localparam logic [1:0] ST_STOP  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_CLEAR = 2'd2;

  localparam int MSEC_W = 7;
  localparam int SEC_W  = 6;
  localparam int MIN_W  = 6;
  localparam int HOUR_W = 5;

  localparam logic [MSEC_W-1:0] MSEC_MAX = 7'd99;
  localparam logic [SEC_W-1:0]  SEC_MAX  = 6'd59;
  localparam logic [MIN_W-1:0]  MIN_MAX  = 6'd59;
  localparam logic [HOUR_W-1:0] HOUR_MAX = 5'd23;

endpackage

// File: rtl/stopwatch_tick_gen.sv
// Clock divider producing a 1-cycle tick every DIV enabled cycles.
// Count is held while disabled; clr zeroes it synchronously.
module stopwatch_tick_gen
  import stopwatch_pkg::*;
#(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt_q;

  assign tick = en && (cnt_q == LAST);

  // Advance while enabled, wrap on the tick cycle.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= tick ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch FSM (STOP/RUN/CLEAR) and h:m:s.cs counter cascade.
// Optional lap hold enabled by defining STOPWATCH_LAP_HOLD_EN.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int TICK_HZ     = 100
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_btn_run_stop,
  input  logic              i_btn_clear,
  input  logic              i_btn_lap,
  output logic [MSEC_W-1:0] o_msec,
  output logic [SEC_W-1:0]  o_sec,
  output logic [MIN_W-1:0]  o_min,
  output logic [HOUR_W-1:0] o_hour,
  output logic              o_running,
  output logic              o_lap_hold
);

  localparam int DIV = CLK_FREQ_HZ / TICK_HZ;

  logic [1:0] state_q;
  logic [1:0] state_d;
  logic       running_q;
  logic       clr_go;
  logic       tick;

  logic [MSEC_W-1:0] msec_q;
  logic [SEC_W-1:0]  sec_q;
  logic [MIN_W-1:0]  min_q;
  logic [HOUR_W-1:0] hour_q;

  logic msec_wrap;
  logic sec_wrap;
  logic min_wrap;
  logic hour_wrap;

  // Clear wins over run/stop when both arrive in STOP.
  assign clr_go = (state_q == ST_STOP) && i_btn_clear;

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      (state_q == ST_STOP): begin
        if (i_btn_clear) begin
          state_d = ST_CLEAR;
        end else if (i_btn_run_stop) begin
          state_d = ST_RUN;
        end
      end
      (state_q == ST_RUN): begin
        if (i_btn_run_stop) begin
          state_d = ST_STOP;
        end
      end
      (state_q == ST_CLEAR): state_d = ST_STOP;
      default:               state_d = ST_STOP;
    endcase
  end

  // State and registered running flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_STOP;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      running_q <= (state_d == ST_RUN);
    end
  end

  stopwatch_tick_gen #(
    .DIV (DIV)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (state_q == ST_RUN),
    .clr  (clr_go),
    .tick (tick)
  );

  assign msec_wrap = (msec_q == MSEC_MAX);
  assign sec_wrap  = (sec_q == SEC_MAX);
  assign min_wrap  = (min_q == MIN_MAX);
  assign hour_wrap = (hour_q == HOUR_MAX);

  // Time cascade, stepped once per tick.
  always_ff @(posedge clk) begin
    if (rst || clr_go) begin
      msec_q <= '0;
      sec_q  <= '0;
      min_q  <= '0;
      hour_q <= '0;
    end else if (tick) begin
      msec_q <= msec_wrap ? '0 : msec_q + 1'b1;
      if (msec_wrap) begin
        sec_q <= sec_wrap ? '0 : sec_q + 1'b1;
        if (sec_wrap) begin
          min_q <= min_wrap ? '0 : min_q + 1'b1;
          if (min_wrap) begin
            hour_q <= hour_wrap ? '0 : hour_q + 1'b1;
          end
        end
      end
    end
  end

  assign o_running = running_q;

`ifdef STOPWATCH_LAP_HOLD_EN
  logic              hold_q;
  logic              lap_go;
  logic [MSEC_W-1:0] snap_msec;
  logic [SEC_W-1:0]  snap_sec;
  logic [MIN_W-1:0]  snap_min;
  logic [HOUR_W-1:0] snap_hour;

  assign lap_go = (state_q == ST_RUN) && i_btn_lap;

  // Lap toggle; snapshot captured when the hold engages.
  always_ff @(posedge clk) begin
    if (rst || clr_go) begin
      hold_q    <= 1'b0;
      snap_msec <= '0;
      snap_sec  <= '0;
      snap_min  <= '0;
      snap_hour <= '0;
    end else if (lap_go) begin
      hold_q <= ~hold_q;
      if (!hold_q) begin
        snap_msec <= msec_q;
        snap_sec  <= sec_q;
        snap_min  <= min_q;
        snap_hour <= hour_q;
      end
    end
  end

  assign o_lap_hold = hold_q;
  assign o_msec     = hold_q ? snap_msec : msec_q;
  assign o_sec      = hold_q ? snap_sec  : sec_q;
  assign o_min      = hold_q ? snap_min  : min_q;
  assign o_hour     = hold_q ? snap_hour : hour_q;
`else
  logic unused_lap;
  assign unused_lap = i_btn_lap;
  assign o_lap_hold = 1'b0;
  assign o_msec     = msec_q;
  assign o_sec      = sec_q;
  assign o_min      = min_q;
  assign o_hour     = hour_q;
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl at DIV=10.
// Lap scenario follows STOPWATCH_LAP_HOLD_EN.
module tb_stopwatch_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn_rs = 1'b0;
  logic       btn_clr = 1'b0;
  logic       btn_lap = 1'b0;
  logic [6:0] msec;
  logic [5:0] sec;
  logic [5:0] min;
  logic [4:0] hour;
  logic       running;
  logic       lap_hold;

  int n_chk = 0;
  int n_fail = 0;

  stopwatch_ctrl #(
    .CLK_FREQ_HZ (1000),
    .TICK_HZ     (100)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .i_btn_run_stop (btn_rs),
    .i_btn_clear    (btn_clr),
    .i_btn_lap      (btn_lap),
    .o_msec         (msec),
    .o_sec          (sec),
    .o_min          (min),
    .o_hour         (hour),
    .o_running      (running),
    .o_lap_hold     (lap_hold)
  );

  always #5 clk = ~clk;

  // All stimulus tasks start and end on a negedge.
  task automatic press_rs();
    btn_rs = 1'b1;
    @(negedge clk);
    btn_rs = 1'b0;
  endtask

  task automatic press_clr();
    btn_clr = 1'b1;
    @(negedge clk);
    btn_clr = 1'b0;
  endtask

  task automatic press_both();
    btn_clr = 1'b1;
    btn_rs  = 1'b1;
    @(negedge clk);
    btn_clr = 1'b0;
    btn_rs  = 1'b0;
  endtask

  task automatic press_lap();
    btn_lap = 1'b1;
    @(negedge clk);
    btn_lap = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    n_chk++;
    if ({hour, min, sec, msec, running, lap_hold} !== 26'd0) begin
      n_fail++;
      $display("FAIL reset_state got %h:%h:%h.%h run=%b lap=%b want all 0",
               hour, min, sec, msec, running, lap_hold);
    end
    repeat (50) @(negedge clk);
    n_chk++;
    if ({hour, min, sec, msec, running} !== 25'd0) begin
      n_fail++;
      $display("FAIL reset_idle got %h:%h:%h.%h run=%b want all 0",
               hour, min, sec, msec, running);
    end
  endtask

  task automatic test_count();
    press_rs();
    repeat (9) @(negedge clk);
    n_chk++;
    if (msec !== 7'd0 || running !== 1'b1) begin
      n_fail++;
      $display("FAIL count_pre_tick got msec=%0d run=%b want 0 1", msec, running);
    end
    @(negedge clk);
    n_chk++;
    if (msec !== 7'd1) begin
      n_fail++;
      $display("FAIL count_first_tick got msec=%0d want 1", msec);
    end
    repeat (990) @(negedge clk);
    n_chk++;
    if (sec !== 6'd1 || msec !== 7'd0) begin
      n_fail++;
      $display("FAIL count_one_sec got sec=%0d msec=%0d want 1 0", sec, msec);
    end
    press_rs();
    press_clr();
    n_chk++;
    if ({hour, min, sec, msec, running} !== 25'd0) begin
      n_fail++;
      $display("FAIL count_clear got %0d:%0d:%0d.%0d run=%b want 0",
               hour, min, sec, msec, running);
    end
    @(negedge clk);
  endtask

  task automatic test_stop_resume();
    press_rs();
    repeat (24) @(negedge clk);
    press_rs();
    n_chk++;
    if (msec !== 7'd2 || running !== 1'b0) begin
      n_fail++;
      $display("FAIL stop_value got msec=%0d run=%b want 2 0", msec, running);
    end
    repeat (100) @(negedge clk);
    n_chk++;
    if (msec !== 7'd2) begin
      n_fail++;
      $display("FAIL stop_hold got msec=%0d want 2", msec);
    end
    press_rs();
    repeat (4) @(negedge clk);
    n_chk++;
    if (msec !== 7'd2) begin
      n_fail++;
      $display("FAIL resume_early got msec=%0d want 2", msec);
    end
    @(negedge clk);
    n_chk++;
    if (msec !== 7'd3) begin
      n_fail++;
      $display("FAIL resume_tick got msec=%0d want 3", msec);
    end
  endtask

  task automatic test_clear();
    press_clr();
    n_chk++;
    if (msec !== 7'd3 || running !== 1'b1) begin
      n_fail++;
      $display("FAIL clear_in_run got msec=%0d run=%b want 3 1", msec, running);
    end
    press_rs();
    press_clr();
    n_chk++;
    if ({hour, min, sec, msec, running} !== 25'd0) begin
      n_fail++;
      $display("FAIL clear_zero got %0d:%0d:%0d.%0d run=%b want 0",
               hour, min, sec, msec, running);
    end
    press_rs();
    n_chk++;
    if (running !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_ignores_rs got run=%b want 0", running);
    end
    repeat (20) @(negedge clk);
    n_chk++;
    if ({msec, running} !== 8'd0) begin
      n_fail++;
      $display("FAIL clear_settles got msec=%0d run=%b want 0 0", msec, running);
    end
    press_rs();
    n_chk++;
    if (running !== 1'b1) begin
      n_fail++;
      $display("FAIL clear_to_stop got run=%b want 1", running);
    end
    repeat (15) @(negedge clk);
    press_rs();
    n_chk++;
    if (msec !== 7'd1 || running !== 1'b0) begin
      n_fail++;
      $display("FAIL preboth_value got msec=%0d run=%b want 1 0", msec, running);
    end
    press_both();
    repeat (5) @(negedge clk);
    n_chk++;
    if ({hour, min, sec, msec, running} !== 25'd0) begin
      n_fail++;
      $display("FAIL both_pulse got %0d:%0d:%0d.%0d run=%b want 0",
               hour, min, sec, msec, running);
    end
  endtask

  task automatic test_wrap();
    dut.msec_q = 7'd99;
    dut.sec_q  = 6'd59;
    dut.min_q  = 6'd59;
    dut.hour_q = 5'd23;
    press_rs();
    repeat (9) @(negedge clk);
    n_chk++;
    if ({hour, min, sec, msec} !== {5'd23, 6'd59, 6'd59, 7'd99}) begin
      n_fail++;
      $display("FAIL wrap_preload got %0d:%0d:%0d.%0d want 23:59:59.99",
               hour, min, sec, msec);
    end
    @(negedge clk);
    n_chk++;
    if ({hour, min, sec, msec} !== 24'd0 || running !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_full got %0d:%0d:%0d.%0d run=%b want 0:0:0.0 1",
               hour, min, sec, msec, running);
    end
  endtask

  task automatic test_reset_mid_run();
    repeat (13) @(negedge clk);
    n_chk++;
    if (msec !== 7'd1) begin
      n_fail++;
      $display("FAIL midrun_pre got msec=%0d want 1", msec);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_chk++;
    if ({hour, min, sec, msec, running} !== 25'd0) begin
      n_fail++;
      $display("FAIL midrun_reset got %0d.%0d run=%b want 0 0", sec, msec, running);
    end
    repeat (30) @(negedge clk);
    n_chk++;
    if ({msec, running} !== 8'd0) begin
      n_fail++;
      $display("FAIL midrun_idle got msec=%0d run=%b want 0 0", msec, running);
    end
  endtask

  task automatic test_lap();
    press_rs();
    repeat (70) @(negedge clk);
    press_lap();
`ifdef STOPWATCH_LAP_HOLD_EN
    n_chk++;
    if (msec !== 7'd7 || lap_hold !== 1'b1) begin
      n_fail++;
      $display("FAIL lap_freeze got msec=%0d hold=%b want 7 1", msec, lap_hold);
    end
    repeat (29) @(negedge clk);
    n_chk++;
    if (msec !== 7'd7) begin
      n_fail++;
      $display("FAIL lap_frozen got msec=%0d want 7", msec);
    end
    press_lap();
    n_chk++;
    if (msec !== 7'd10 || lap_hold !== 1'b0) begin
      n_fail++;
      $display("FAIL lap_release got msec=%0d hold=%b want 10 0", msec, lap_hold);
    end
`else
    n_chk++;
    if (msec !== 7'd7 || lap_hold !== 1'b0) begin
      n_fail++;
      $display("FAIL lap_ignored got msec=%0d hold=%b want 7 0", msec, lap_hold);
    end
    repeat (29) @(negedge clk);
    n_chk++;
    if (msec !== 7'd10) begin
      n_fail++;
      $display("FAIL lap_live got msec=%0d want 10", msec);
    end
`endif
    press_rs();
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_count();
    test_stop_resume();
    test_clear();
    test_wrap();
    test_reset_mid_run();
    test_lap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
